// File: rtl/issue_window_pkg.sv
// Shared types and constants for the four-entry in-order issue window.
package issue_window_pkg;

  localparam int WINDOW_DEPTH = 4;
  localparam int DEF_DW       = 4;
  localparam int DEF_SW       = 4;
  localparam int DEF_OPW      = 8;

  typedef struct packed {
    logic [DEF_OPW-1:0] op;
    logic [DEF_DW-1:0]  des;
    logic [DEF_SW-1:0]  s1;
    logic [DEF_SW-1:0]  s2;
  } ins_t;

  function automatic logic [2:0] count_ones4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/issue_window_prefix.sv
// In-order prefix issue: slot N issues only if every older slot issues and its hazard flag is set.
module issue_prefix
  import issue_window_pkg::*;
(
  input  logic [WINDOW_DEPTH-1:0] slot_valid,
  input  logic                    ins_flag_2,
  input  logic                    ins_flag_3,
  input  logic                    ins_flag_4,
  input  logic                    issue_ready,
  input  logic                    kill,
  output logic [WINDOW_DEPTH-1:0] iss_valid,
  output logic [2:0]              iss_count
);

  // Flags of invalid slots are masked by slot_valid so a stale verdict cannot issue a hole.
  assign iss_valid[0] = slot_valid[0] && issue_ready && !kill;
  assign iss_valid[1] = iss_valid[0] && slot_valid[1] && ins_flag_2;
  assign iss_valid[2] = iss_valid[1] && slot_valid[2] && ins_flag_3;
  assign iss_valid[3] = iss_valid[2] && slot_valid[3] && ins_flag_4;

  assign iss_count = count_ones4(iss_valid);

endmodule

// File: rtl/issue_window.sv
// Four-slot in-order issue window: oldest instruction in slot 1, issued prefix shifts out,
// new instruction appended behind the survivors.
module issue_window
  import issue_window_pkg::*;
#(
  parameter int DW  = 4,
  parameter int SW  = 4,
  parameter int OPW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_op,
  input  logic [DW-1:0]  in_des,
  input  logic [SW-1:0]  in_s1,
  input  logic [SW-1:0]  in_s2,
  output logic           slot1_valid,
  output logic           slot2_valid,
  output logic           slot3_valid,
  output logic           slot4_valid,
  output logic [OPW-1:0] slot1_op,
  output logic [DW-1:0]  slot1_des,
  output logic [SW-1:0]  slot1_s1,
  output logic [SW-1:0]  slot1_s2,
  output logic [OPW-1:0] slot2_op,
  output logic [DW-1:0]  slot2_des,
  output logic [SW-1:0]  slot2_s1,
  output logic [SW-1:0]  slot2_s2,
  output logic [OPW-1:0] slot3_op,
  output logic [DW-1:0]  slot3_des,
  output logic [SW-1:0]  slot3_s1,
  output logic [SW-1:0]  slot3_s2,
  output logic [OPW-1:0] slot4_op,
  output logic [DW-1:0]  slot4_des,
  output logic [SW-1:0]  slot4_s1,
  output logic [SW-1:0]  slot4_s2,
  input  logic           ins_flag_2,
  input  logic           ins_flag_3,
  input  logic           ins_flag_4,
  input  logic           issue_ready,
  input  logic           flush,
  output logic           iss_valid1,
  output logic           iss_valid2,
  output logic           iss_valid3,
  output logic           iss_valid4,
  output logic [2:0]     iss_count
);

  logic [2:0]              cnt_q, cnt_n;
  logic [WINDOW_DEPTH-1:0] slot_valid;
  logic [WINDOW_DEPTH-1:0] iss_valid;
  logic                    enq;
  logic [2:0]              enq_pos;

  logic [OPW-1:0] op_q  [WINDOW_DEPTH];
  logic [DW-1:0]  des_q [WINDOW_DEPTH];
  logic [SW-1:0]  s1_q  [WINDOW_DEPTH];
  logic [SW-1:0]  s2_q  [WINDOW_DEPTH];
  logic [OPW-1:0] op_n  [WINDOW_DEPTH];
  logic [DW-1:0]  des_n [WINDOW_DEPTH];
  logic [SW-1:0]  s1_n  [WINDOW_DEPTH];
  logic [SW-1:0]  s2_n  [WINDOW_DEPTH];

  always_comb begin
    for (int i = 0; i < WINDOW_DEPTH; i++) begin
      slot_valid[i] = (cnt_q > 3'(i));
    end
  end

  issue_prefix u_prefix (
    .slot_valid  (slot_valid),
    .ins_flag_2  (ins_flag_2),
    .ins_flag_3  (ins_flag_3),
    .ins_flag_4  (ins_flag_4),
    .issue_ready (issue_ready),
    .kill        (flush || rst),
    .iss_valid   (iss_valid),
    .iss_count   (iss_count)
  );

  // Full means no enqueue even if slots drain this cycle; keeps in_ready off the issue path.
  assign in_ready = !rst && !flush && (cnt_q < 3'(WINDOW_DEPTH));
  assign enq      = in_valid && in_ready;
  assign enq_pos  = cnt_q - iss_count;

  always_comb begin
    logic [2:0] src;
    for (int i = 0; i < WINDOW_DEPTH; i++) begin
      op_n[i]  = op_q[i];
      des_n[i] = des_q[i];
      s1_n[i]  = s1_q[i];
      s2_n[i]  = s2_q[i];
      src = 3'(i) + iss_count;
      if (src < cnt_q) begin
        op_n[i]  = op_q[src[1:0]];
        des_n[i] = des_q[src[1:0]];
        s1_n[i]  = s1_q[src[1:0]];
        s2_n[i]  = s2_q[src[1:0]];
      end
      if (enq && (enq_pos == 3'(i))) begin
        op_n[i]  = in_op;
        des_n[i] = in_des;
        s1_n[i]  = in_s1;
        s2_n[i]  = in_s2;
      end
    end
    cnt_n = cnt_q - iss_count + {2'b00, enq};
    if (flush) begin
      cnt_n = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WINDOW_DEPTH; i++) begin
      op_q[i]  <= op_n[i];
      des_q[i] <= des_n[i];
      s1_q[i]  <= s1_n[i];
      s2_q[i]  <= s2_n[i];
    end
  end

  assign slot1_valid = slot_valid[0];
  assign slot2_valid = slot_valid[1];
  assign slot3_valid = slot_valid[2];
  assign slot4_valid = slot_valid[3];

  assign slot1_op = op_q[0];
  assign slot1_des = des_q[0];
  assign slot1_s1 = s1_q[0];
  assign slot1_s2 = s2_q[0];
  assign slot2_op = op_q[1];
  assign slot2_des = des_q[1];
  assign slot2_s1 = s1_q[1];
  assign slot2_s2 = s2_q[1];
  assign slot3_op = op_q[2];
  assign slot3_des = des_q[2];
  assign slot3_s1 = s1_q[2];
  assign slot3_s2 = s2_q[2];
  assign slot4_op = op_q[3];
  assign slot4_des = des_q[3];
  assign slot4_s1 = s1_q[3];
  assign slot4_s2 = s2_q[3];

  assign iss_valid1 = iss_valid[0];
  assign iss_valid2 = iss_valid[1];
  assign iss_valid3 = iss_valid[2];
  assign iss_valid4 = iss_valid[3];

endmodule

// File: tb/tb_issue_window.sv
// Directed table-driven bench for issue_window: per-cycle inputs, expected combinational
// issue outputs, and expected post-edge occupancy and slot contents.
module tb_issue_window;
  import issue_window_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_op;
  logic [3:0] in_des, in_s1, in_s2;
  logic       slot1_valid, slot2_valid, slot3_valid, slot4_valid;
  logic [7:0] slot1_op, slot2_op, slot3_op, slot4_op;
  logic [3:0] slot1_des, slot2_des, slot3_des, slot4_des;
  logic [3:0] slot1_s1, slot2_s1, slot3_s1, slot4_s1;
  logic [3:0] slot1_s2, slot2_s2, slot3_s2, slot4_s2;
  logic       ins_flag_2, ins_flag_3, ins_flag_4;
  logic       issue_ready;
  logic       flush;
  logic       iss_valid1, iss_valid2, iss_valid3, iss_valid4;
  logic [2:0] iss_count;

  int checks_total;
  int checks_passed;

  issue_window #(.DW(4), .SW(4), .OPW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_des(in_des), .in_s1(in_s1), .in_s2(in_s2),
    .slot1_valid(slot1_valid), .slot2_valid(slot2_valid),
    .slot3_valid(slot3_valid), .slot4_valid(slot4_valid),
    .slot1_op(slot1_op), .slot1_des(slot1_des), .slot1_s1(slot1_s1), .slot1_s2(slot1_s2),
    .slot2_op(slot2_op), .slot2_des(slot2_des), .slot2_s1(slot2_s1), .slot2_s2(slot2_s2),
    .slot3_op(slot3_op), .slot3_des(slot3_des), .slot3_s1(slot3_s1), .slot3_s2(slot3_s2),
    .slot4_op(slot4_op), .slot4_des(slot4_des), .slot4_s1(slot4_s1), .slot4_s2(slot4_s2),
    .ins_flag_2(ins_flag_2), .ins_flag_3(ins_flag_3), .ins_flag_4(ins_flag_4),
    .issue_ready(issue_ready), .flush(flush),
    .iss_valid1(iss_valid1), .iss_valid2(iss_valid2),
    .iss_valid3(iss_valid3), .iss_valid4(iss_valid4),
    .iss_count(iss_count)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic [7:0] op;
    logic       issue_ready;
    logic [2:0] flags;       // {flag4, flag3, flag2}
    logic       exp_ready;
    logic [3:0] exp_iss;     // {iss4, iss3, iss2, iss1}
    logic [2:0] exp_count;
    int         exp_cnt;     // occupancy after the edge
    logic [31:0] exp_ops;    // {slot4, slot3, slot2, slot1} op after the edge
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic [7:0] op,
                              input logic ir, input logic [2:0] fl, input logic er,
                              input logic [3:0] ei, input logic [2:0] ec, input int cn,
                              input logic [31:0] eo);
    vec_t v;
    v.rst = r; v.flush = f; v.in_valid = iv; v.op = op; v.issue_ready = ir; v.flags = fl;
    v.exp_ready = er; v.exp_iss = ei; v.exp_count = ec; v.exp_cnt = cn; v.exp_ops = eo;
    return v;
  endfunction

  // Other fields are derived from the opcode so every field path is observable.
  function automatic ins_t mk_ins(input logic [7:0] op);
    ins_t t;
    t.op = op; t.des = op[3:0]; t.s1 = op[7:4]; t.s2 = ~op[3:0];
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Driver task
  task automatic drive(input logic r, input logic f, input logic iv, input logic [7:0] op,
                       input logic ir, input logic [2:0] fl);
    ins_t t;
    t = mk_ins(op);
    rst = r; flush = f; in_valid = iv; issue_ready = ir;
    in_op = t.op; in_des = t.des; in_s1 = t.s1; in_s2 = t.s2;
    {ins_flag_4, ins_flag_3, ins_flag_2} = fl;
  endtask

  task automatic check_state(input string tag, input int cn, input logic [31:0] ops);
    logic [7:0] op_arr [4];
    logic [3:0] des_arr [4];
    logic [3:0] s1_arr [4];
    logic [3:0] s2_arr [4];
    ins_t e;
    op_arr = '{slot1_op, slot2_op, slot3_op, slot4_op};
    des_arr = '{slot1_des, slot2_des, slot3_des, slot4_des};
    s1_arr = '{slot1_s1, slot2_s1, slot3_s1, slot4_s1};
    s2_arr = '{slot1_s2, slot2_s2, slot3_s2, slot4_s2};
    check({tag, " slot_valid"}, 32'({slot4_valid, slot3_valid, slot2_valid, slot1_valid}),
          32'((1 << cn) - 1));
    for (int n = 0; n < cn; n++) begin
      e = mk_ins(ops[8*n +: 8]);
      check($sformatf("%s slot%0d_op", tag, n + 1), 32'(op_arr[n]), 32'(e.op));
      if (n == 0) begin
        check({tag, " slot1_des"}, 32'(des_arr[0]), 32'(e.des));
        check({tag, " slot1_s1"}, 32'(s1_arr[0]), 32'(e.s1));
        check({tag, " slot1_s2"}, 32'(s2_arr[0]), 32'(e.s2));
      end
    end
  endtask

  task automatic check_comb(input string tag, input logic er, input logic [3:0] ei,
                            input logic [2:0] ec);
    check({tag, " in_ready"}, 32'(in_ready), 32'(er));
    check({tag, " iss_valid"}, 32'({iss_valid4, iss_valid3, iss_valid2, iss_valid1}), 32'(ei));
    check({tag, " iss_count"}, 32'(iss_count), 32'(ec));
  endtask

  initial begin
    checks_total = 0;
    checks_passed = 0;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000);

    //        rst flush iv  op     ir  flags   rdy iss      cnt   occ ops{4,3,2,1}
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 3'b000, 0, 4'b0000, 3'd0, 0, 32'h0000_0000));
    vecs.push_back(mk(0, 0, 1, 8'h11, 0, 3'b000, 1, 4'b0000, 3'd0, 1, 32'h0000_0011));
    vecs.push_back(mk(0, 0, 1, 8'h22, 0, 3'b000, 1, 4'b0000, 3'd0, 2, 32'h0000_2211));
    vecs.push_back(mk(0, 0, 1, 8'h33, 0, 3'b000, 1, 4'b0000, 3'd0, 3, 32'h0033_2211));
    vecs.push_back(mk(0, 0, 1, 8'h44, 0, 3'b000, 1, 4'b0000, 3'd0, 4, 32'h4433_2211));
    vecs.push_back(mk(0, 0, 1, 8'h99, 0, 3'b111, 0, 4'b0000, 3'd0, 4, 32'h4433_2211));
    vecs.push_back(mk(0, 0, 1, 8'h98, 1, 3'b101, 0, 4'b0011, 3'd2, 2, 32'h0000_4433));
    vecs.push_back(mk(0, 0, 1, 8'h55, 1, 3'b111, 1, 4'b0011, 3'd2, 1, 32'h0000_0055));
    vecs.push_back(mk(0, 0, 1, 8'h66, 0, 3'b111, 1, 4'b0000, 3'd0, 2, 32'h0000_6655));
    vecs.push_back(mk(0, 0, 1, 8'h77, 0, 3'b000, 1, 4'b0000, 3'd0, 3, 32'h0077_6655));
    vecs.push_back(mk(0, 0, 1, 8'h88, 1, 3'b110, 1, 4'b0001, 3'd1, 3, 32'h0088_7766));
    vecs.push_back(mk(0, 1, 1, 8'h99, 1, 3'b111, 0, 4'b0000, 3'd0, 0, 32'h0000_0000));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 3'b111, 1, 4'b0000, 3'd0, 0, 32'h0000_0000));
    vecs.push_back(mk(0, 0, 1, 8'h05, 1, 3'b111, 1, 4'b0000, 3'd0, 1, 32'h0000_0005));
    vecs.push_back(mk(0, 0, 1, 8'h06, 1, 3'b111, 1, 4'b0001, 3'd1, 1, 32'h0000_0006));
    vecs.push_back(mk(0, 0, 1, 8'hA1, 0, 3'b111, 1, 4'b0000, 3'd0, 2, 32'h0000_A106));
    vecs.push_back(mk(0, 0, 1, 8'hA2, 0, 3'b111, 1, 4'b0000, 3'd0, 3, 32'h00A2_A106));
    vecs.push_back(mk(0, 0, 1, 8'hA3, 0, 3'b111, 1, 4'b0000, 3'd0, 4, 32'hA3A2_A106));
    vecs.push_back(mk(1, 0, 1, 8'hA4, 1, 3'b111, 0, 4'b0000, 3'd0, 0, 32'h0000_0000));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 3'b000, 1, 4'b0000, 3'd0, 0, 32'h0000_0000));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].flush, vecs[i].in_valid, vecs[i].op,
            vecs[i].issue_ready, vecs[i].flags);
      #1;
      check_comb($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_iss, vecs[i].exp_count);
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_ops);
    end

    // Hand-written sequence: fill to four, then drain all four in one cycle.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 8'hC1 + 8'(k), 1'b0, 3'b111);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'b111);
    #1;
    check_state("fill", 4, 32'hC4C3_C2C1);
    check_comb("fill hold", 1'b0, 4'b0000, 3'd0);
    issue_ready = 1'b1;
    #1;
    check_comb("drain all", 1'b0, 4'b1111, 3'd4);
    @(posedge clk);
    #1;
    check_state("drain all", 0, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000);
    #1;
    check_comb("after drain", 1'b1, 4'b0000, 3'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
